// File: rtl/pic_boot_pkg.sv
// Shared types and constants for the PIC boot path: loader states, UFM burst
// setting and program RAM geometry.
package pic_boot_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_REQ       = 3'd1,
        ST_WAIT_DATA = 3'd2,
        ST_WRITE     = 3'd3,
        ST_DONE      = 3'd4,
        ST_ERROR     = 3'd5
    } loader_state_e;

    localparam logic [1:0] UFM_BURSTCOUNT = 2'd1;

    localparam int         PROG_RAM_WORDS = 512;
    localparam int         PROG_RAM_DW    = 32;
    localparam int         PROG_RAM_AW    = 9;
    localparam logic [3:0] PROG_RAM_BE    = 4'hF;

endpackage

// File: rtl/ufm_rom_shadow_loader.sv
// Copies the PIC program image from UFM into the program RAM at boot and keeps
// the PIC core in reset until the whole image has landed.
module ufm_rom_shadow_loader
    import pic_boot_pkg::*;
#(
    parameter int          WORDS      = PROG_RAM_WORDS,
    parameter logic [15:0] UFM_BASE   = 16'h0000,
    parameter int          ROM_AW     = PROG_RAM_AW,
    parameter int          TIMEOUT    = 255,
    parameter bit          AUTO_START = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   i_start,
    output logic [15:0]            o_ufm_addr,
    output logic                   o_ufm_read,
    output logic [1:0]             o_ufm_burstcount,
    input  logic                   i_ufm_waitreq,
    input  logic                   i_ufm_valid,
    input  logic [31:0]            i_ufm_data,
    output logic [ROM_AW-1:0]      o_rom_wr_addr,
    output logic [PROG_RAM_DW-1:0] o_rom_wr_data,
    output logic [3:0]             o_rom_wr_be,
    output logic                   o_rom_wr_we,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_error,
    output logic [31:0]            o_checksum,
    output logic                   o_cpu_reset_n
);

    localparam int              CW       = $clog2(TIMEOUT + 1);
    localparam logic [ROM_AW-1:0] LAST_IDX = ROM_AW'(WORDS - 1);
    localparam logic [CW-1:0]   TMO_LAST = CW'(TIMEOUT - 1);

    if ((WORDS < 1) || (WORDS > (2 ** ROM_AW)) || (TIMEOUT < 1) || (ROM_AW > 16)) begin : g_bad_cfg
        $error("ufm_rom_shadow_loader: WORDS must fit the ROM_AW index and TIMEOUT must be >= 1");
    end

    loader_state_e     state_q, state_d;
    logic [ROM_AW-1:0] index_q, index_d;
    logic [CW-1:0]     tmo_q, tmo_d;
    logic [31:0]       data_q, data_d;
    logic [31:0]       sum_q, sum_d;

    logic        ufm_read_q, ufm_read_d;
    logic [15:0] ufm_addr_q, ufm_addr_d;
    logic        wr_we_q, wr_we_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
    logic        cpu_rst_n_q, cpu_rst_n_d;

    // Next-state and datapath: one outstanding read, timeout only counts while waiting for data.
    always_comb begin
        state_d = state_q;
        index_d = index_q;
        tmo_d   = tmo_q;
        data_d  = data_q;
        sum_d   = sum_q;
        case (state_q)
            ST_IDLE: begin
                if (AUTO_START || i_start) begin
                    state_d = ST_REQ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (!i_ufm_waitreq) begin
                    tmo_d   = '0;
                    state_d = ST_WAIT_DATA;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_WAIT_DATA: begin
                if (i_ufm_valid) begin
                    data_d  = i_ufm_data;
                    state_d = ST_WRITE;
                end else if (tmo_q == TMO_LAST) begin
                    tmo_d   = tmo_q + 1'b1;
                    state_d = ST_ERROR;
                end else begin
                    tmo_d   = tmo_q + 1'b1;
                end
            end
            ST_WRITE: begin
                sum_d = sum_q + data_q;
                if (index_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end else begin
                    index_d = index_q + 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_DONE, ST_ERROR: begin
                if (i_start) begin
                    index_d = '0;
                    sum_d   = '0;
                    state_d = ST_REQ;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they come straight off flops.
    always_comb begin
        ufm_read_d  = (state_d == ST_REQ);
        ufm_addr_d  = UFM_BASE + 16'(index_d);
        wr_we_d     = (state_d == ST_WRITE);
        busy_d      = (state_d == ST_REQ) || (state_d == ST_WAIT_DATA) || (state_d == ST_WRITE);
        done_d      = (state_d == ST_DONE);
        error_d     = (state_d == ST_ERROR);
        cpu_rst_n_d = (state_d == ST_DONE);
    end

    // State, counters and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            index_q     <= '0;
            tmo_q       <= '0;
            data_q      <= 32'h0000_0000;
            sum_q       <= 32'h0000_0000;
            ufm_read_q  <= 1'b0;
            ufm_addr_q  <= 16'h0000;
            wr_we_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            cpu_rst_n_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            index_q     <= index_d;
            tmo_q       <= tmo_d;
            data_q      <= data_d;
            sum_q       <= sum_d;
            ufm_read_q  <= ufm_read_d;
            ufm_addr_q  <= ufm_addr_d;
            wr_we_q     <= wr_we_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            cpu_rst_n_q <= cpu_rst_n_d;
        end
    end

    assign o_ufm_addr       = ufm_addr_q;
    assign o_ufm_read       = ufm_read_q;
    assign o_ufm_burstcount = UFM_BURSTCOUNT;
    assign o_rom_wr_addr    = index_q;
    assign o_rom_wr_data    = data_q;
    assign o_rom_wr_be      = PROG_RAM_BE & {4{wr_we_q}};
    assign o_rom_wr_we      = wr_we_q;
    assign o_busy           = busy_q;
    assign o_done           = done_q;
    assign o_error          = error_q;
    assign o_checksum       = sum_q;
    assign o_cpu_reset_n    = cpu_rst_n_q;

endmodule

// File: tb/tb_ufm_rom_shadow_loader.sv
// Randomized bench for ufm_rom_shadow_loader: a UFM responder with random
// latency/waitrequest and an image/checksum reference computed from the image.
module tb_ufm_rom_shadow_loader;

    localparam int          WORDS   = 4;
    localparam int          TIMEOUT = 8;
    localparam logic [15:0] BASE    = 16'h0000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        i_start;
    logic [15:0] o_ufm_addr;
    logic        o_ufm_read;
    logic [1:0]  o_ufm_burstcount;
    logic        i_ufm_waitreq;
    logic        i_ufm_valid;
    logic [31:0] i_ufm_data;
    logic [8:0]  o_rom_wr_addr;
    logic [31:0] o_rom_wr_data;
    logic [3:0]  o_rom_wr_be;
    logic        o_rom_wr_we;
    logic        o_busy;
    logic        o_done;
    logic        o_error;
    logic [31:0] o_checksum;
    logic        o_cpu_reset_n;

    ufm_rom_shadow_loader #(
        .WORDS(WORDS), .UFM_BASE(BASE), .ROM_AW(9), .TIMEOUT(TIMEOUT), .AUTO_START(1'b1)
    ) dut (
        .clk(clk), .reset_n(reset_n), .i_start(i_start),
        .o_ufm_addr(o_ufm_addr), .o_ufm_read(o_ufm_read), .o_ufm_burstcount(o_ufm_burstcount),
        .i_ufm_waitreq(i_ufm_waitreq), .i_ufm_valid(i_ufm_valid), .i_ufm_data(i_ufm_data),
        .o_rom_wr_addr(o_rom_wr_addr), .o_rom_wr_data(o_rom_wr_data), .o_rom_wr_be(o_rom_wr_be),
        .o_rom_wr_we(o_rom_wr_we), .o_busy(o_busy), .o_done(o_done), .o_error(o_error),
        .o_checksum(o_checksum), .o_cpu_reset_n(o_cpu_reset_n)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    // Responder knobs, set by the main flow.
    int          lat_lo = 2, lat_hi = 2;
    int          hold_word = -1, hold_left = 0;
    int          drop_word = -1;
    bit          stray_en = 1'b0;
    logic [31:0] pattern = 32'hA500_0000;

    // Responder / monitor state.
    bit          pend = 1'b0, holding = 1'b0, acc_prev = 1'b0;
    int          pend_cnt = 0;
    logic [15:0] pend_addr = 16'h0000;
    int          accepts = 0, acc_cyc = 0, exp_idx = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ufm_word(input logic [15:0] a);
        return pattern | {16'h0000, a};
    endfunction

    function automatic logic [31:0] image_sum(input int n);
        logic [31:0] s = 32'h0000_0000;
        for (int i = 0; i < n; i++) s = s + ufm_word(BASE + 16'(i));
        return s;
    endfunction

    // UFM responder plus write monitor, both evaluated on the falling edge.
    initial begin
        i_ufm_waitreq = 1'b0;
        i_ufm_valid   = 1'b0;
        i_ufm_data    = 32'h0000_0000;
        forever begin
            @(negedge clk);
            i_ufm_valid   = 1'b0;
            i_ufm_waitreq = 1'b0;
            if (!reset_n) begin
                pend = 1'b0; holding = 1'b0; acc_prev = 1'b0;
                continue;
            end
            if (acc_prev) begin
                chk("read_drop", 32'(o_ufm_read), 32'd0);
                acc_prev = 1'b0;
            end
            if (o_rom_wr_we) begin
                chk("wr_addr", 32'(o_rom_wr_addr), 32'(exp_idx));
                chk("wr_data", o_rom_wr_data, ufm_word(BASE + 16'(exp_idx)));
                chk("wr_be", 32'(o_rom_wr_be), 32'hF);
                exp_idx++;
            end else begin
                chk("be_idle", 32'(o_rom_wr_be), 32'h0);
            end
            if (pend) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    pend        = 1'b0;
                    i_ufm_valid = 1'b1;
                    i_ufm_data  = ufm_word(pend_addr);
                end
            end
            if (hold_left > 0 && (holding || (o_ufm_read && accepts == hold_word))) begin
                holding = 1'b1;
                chk("hold_read", 32'(o_ufm_read), 32'd1);
                chk("hold_addr", 32'(o_ufm_addr), 32'(BASE) + 32'(hold_word));
                i_ufm_waitreq = 1'b1;
                if (stray_en && hold_left == 3) begin
                    i_ufm_valid = 1'b1;
                    i_ufm_data  = $urandom;
                end
                hold_left--;
            end else if (o_ufm_read) begin
                holding  = 1'b0;
                accepts++;
                acc_cyc  = cyc + 1;
                acc_prev = 1'b1;
                if (o_ufm_addr != BASE + 16'(drop_word)) begin
                    pend      = 1'b1;
                    pend_cnt  = $urandom_range(lat_hi, lat_lo);
                    pend_addr = o_ufm_addr;
                end
            end
        end
    end

    task automatic wait_end(input int budget);
        int n = 0;
        while (!(o_done || o_error) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!(o_done || o_error)) chk("end_timeout", 32'd0, 32'd1);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        exp_idx = 0;
        accepts = 0;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic check_done(input string tag);
        chk({tag, "_done"}, 32'(o_done), 32'd1);
        chk({tag, "_err"}, 32'(o_error), 32'd0);
        chk({tag, "_cpu"}, 32'(o_cpu_reset_n), 32'd1);
        chk({tag, "_busy"}, 32'(o_busy), 32'd0);
        chk({tag, "_sum"}, o_checksum, image_sum(WORDS));
        chk({tag, "_nwr"}, 32'(exp_idx), 32'(WORDS));
        chk({tag, "_nacc"}, 32'(accepts), 32'(WORDS));
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_read"}, 32'(o_ufm_read), 32'd0);
        chk({tag, "_addr"}, 32'(o_ufm_addr), 32'd0);
        chk({tag, "_we"}, 32'(o_rom_wr_we), 32'd0);
        chk({tag, "_be"}, 32'(o_rom_wr_be), 32'd0);
        chk({tag, "_wa"}, 32'(o_rom_wr_addr), 32'd0);
        chk({tag, "_wd"}, o_rom_wr_data, 32'd0);
        chk({tag, "_flags"}, 32'({o_busy, o_done, o_error, o_cpu_reset_n}), 32'd0);
        chk({tag, "_sum"}, o_checksum, 32'd0);
        chk({tag, "_burst"}, 32'(o_ufm_burstcount), 32'd1);
    endtask

    initial begin
        int n;
        int err_cyc;
        logic [31:0] frozen;
        reset_n = 1'b0;
        i_start = 1'b0;
        repeat (3) @(negedge clk);
        check_cleared("rst");

        // Auto-start copy with the fixed A5 image and latency 2.
        exp_idx = 0;
        accepts = 0;
        reset_n = 1'b1;
        n = 0;
        while (!o_rom_wr_we && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("first_wr_lat", 32'(n), 32'd4);
        wait_end(500);
        check_done("boot");
        chk("boot_sum_const", o_checksum, 32'h9400_0006);

        // Restarts from DONE with waitreq hold, stray valid and a mid-copy start pulse.
        for (int it = 0; it < 4; it++) begin
            pattern   = (it == 0) ? 32'hA500_0000 : ($urandom & 32'hFFFF_0000);
            lat_lo    = 1;
            lat_hi    = 4;
            hold_word = 1;
            hold_left = 5;
            stray_en  = 1'b1;
            @(negedge clk);
            exp_idx = 0;
            accepts = 0;
            i_start = 1'b1;
            @(posedge clk);
            #1;
            chk("restart_cpu_fall", 32'(o_cpu_reset_n), 32'd0);
            chk("restart_done_clr", 32'(o_done), 32'd0);
            chk("restart_busy", 32'(o_busy), 32'd1);
            @(negedge clk);
            i_start = 1'b0;
            repeat ($urandom_range(8, 2)) @(negedge clk);
            i_start = 1'b1;
            @(negedge clk);
            i_start = 1'b0;
            wait_end(1000);
            check_done("recopy");
            if (it == 0) chk("recopy_sum_const", o_checksum, 32'h9400_0006);
        end
        hold_left = 0;
        stray_en  = 1'b0;

        // Word 2 never returns data: timeout into ERROR.
        pattern   = $urandom & 32'hFFFF_0000;
        lat_lo    = 1;
        lat_hi    = 3;
        drop_word = 2;
        pulse_start();
        wait_end(1000);
        err_cyc = cyc;
        chk("tmo_error", 32'(o_error), 32'd1);
        chk("tmo_done", 32'(o_done), 32'd0);
        chk("tmo_cpu", 32'(o_cpu_reset_n), 32'd0);
        chk("tmo_busy", 32'(o_busy), 32'd0);
        chk("tmo_latency", 32'(err_cyc - acc_cyc), 32'(TIMEOUT));
        chk("tmo_nwr", 32'(exp_idx), 32'd2);
        chk("tmo_sum", o_checksum, image_sum(2));
        frozen = o_checksum;
        repeat (5) @(negedge clk);
        chk("tmo_frozen_sum", o_checksum, frozen);
        chk("tmo_frozen_err", 32'(o_error), 32'd1);

        // Recover from ERROR with a healthy responder.
        drop_word = -1;
        pattern   = 32'hA500_0000;
        pulse_start();
        chk("recover_err_clr", 32'(o_error), 32'd0);
        wait_end(1000);
        check_done("recover");
        chk("recover_sum_const", o_checksum, 32'h9400_0006);

        // Asynchronous reset while waiting for word 2.
        pattern = $urandom & 32'hFFFF_0000;
        lat_lo  = 3;
        lat_hi  = 4;
        pulse_start();
        n = 0;
        while (accepts < 3 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("mid_reached_w2", 32'(accepts), 32'd3);
        @(negedge clk);
        chk("mid_in_wait", 32'(o_ufm_read), 32'd0);
        reset_n = 1'b0;
        #1;
        check_cleared("midrst");
        repeat (2) @(negedge clk);
        exp_idx = 0;
        accepts = 0;
        reset_n = 1'b1;
        wait_end(1000);
        check_done("after_rst");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

endmodule
